// File: rtl/alu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_pkg: control encodings, decode helper and FSM states for    |
// | alu_muldiv_unit.                            Rev 1.0             |
// +-----------------------------------------------------------------+
package alu_pkg;

  localparam logic [3:0] c_CTRL_AND   = 4'b0000;
  localparam logic [3:0] c_CTRL_OR    = 4'b0001;
  localparam logic [3:0] c_CTRL_ADD   = 4'b0010;
  localparam logic [3:0] c_CTRL_XOR   = 4'b0011;
  localparam logic [3:0] c_CTRL_SUB   = 4'b0110;
  localparam logic [3:0] c_CTRL_SLT   = 4'b0111;
  localparam logic [3:0] c_CTRL_SLTU  = 4'b1000;
  localparam logic [3:0] c_CTRL_MFHI  = 4'b1001;
  localparam logic [3:0] c_CTRL_MFLO  = 4'b1010;
  localparam logic [3:0] c_CTRL_MULT  = 4'b1011;
  localparam logic [3:0] c_CTRL_MULTU = 4'b1100;
  localparam logic [3:0] c_CTRL_DIV   = 4'b1101;
  localparam logic [3:0] c_CTRL_DIVU  = 4'b1110;
  localparam logic [3:0] c_CTRL_NOR   = 4'b1111;

  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] c_ALUOP_OR    = 2'b11;

  localparam logic [5:0] c_FN_ADD   = 6'b100000;
  localparam logic [5:0] c_FN_ADDU  = 6'b100001;
  localparam logic [5:0] c_FN_SUB   = 6'b100010;
  localparam logic [5:0] c_FN_SUBU  = 6'b100011;
  localparam logic [5:0] c_FN_AND   = 6'b100100;
  localparam logic [5:0] c_FN_OR    = 6'b100101;
  localparam logic [5:0] c_FN_XOR   = 6'b100110;
  localparam logic [5:0] c_FN_NOR   = 6'b100111;
  localparam logic [5:0] c_FN_SLT   = 6'b101010;
  localparam logic [5:0] c_FN_SLTU  = 6'b101011;
  localparam logic [5:0] c_FN_MFHI  = 6'b010000;
  localparam logic [5:0] c_FN_MFLO  = 6'b010010;
  localparam logic [5:0] c_FN_MULT  = 6'b011000;
  localparam logic [5:0] c_FN_MULTU = 6'b011001;
  localparam logic [5:0] c_FN_DIV   = 6'b011010;
  localparam logic [5:0] c_FN_DIVU  = 6'b011011;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       illegal;
  } dec_t;

  function automatic dec_t alu_decode(input logic [1:0] aluop, input logic [5:0] fn);
    dec_t d;
    d.ctrl    = c_CTRL_AND;
    d.illegal = 1'b0;
    case (aluop)
      c_ALUOP_ADD: d.ctrl = c_CTRL_ADD;
      c_ALUOP_SUB: d.ctrl = c_CTRL_SUB;
      c_ALUOP_OR:  d.ctrl = c_CTRL_OR;
      default: begin
        case (fn)
          c_FN_ADD, c_FN_ADDU: d.ctrl = c_CTRL_ADD;
          c_FN_SUB, c_FN_SUBU: d.ctrl = c_CTRL_SUB;
          c_FN_AND:   d.ctrl = c_CTRL_AND;
          c_FN_OR:    d.ctrl = c_CTRL_OR;
          c_FN_XOR:   d.ctrl = c_CTRL_XOR;
          c_FN_NOR:   d.ctrl = c_CTRL_NOR;
          c_FN_SLT:   d.ctrl = c_CTRL_SLT;
          c_FN_SLTU:  d.ctrl = c_CTRL_SLTU;
          c_FN_MFHI:  d.ctrl = c_CTRL_MFHI;
          c_FN_MFLO:  d.ctrl = c_CTRL_MFLO;
          c_FN_MULT:  d.ctrl = c_CTRL_MULT;
          c_FN_MULTU: d.ctrl = c_CTRL_MULTU;
          c_FN_DIV:   d.ctrl = c_CTRL_DIV;
          c_FN_DIVU:  d.ctrl = c_CTRL_DIVU;
          default:    d.illegal = 1'b1;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_muldiv_iter: shift-add multiply / restoring divide on        |
// | operand magnitudes with final sign fix.     Rev 1.0             |
// +-----------------------------------------------------------------+
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_div,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_step,
  output logic             o_last,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);

  // r_hi: accumulator (mul) or remainder (div); r_lo: multiplier or dividend/quotient
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_mag_b;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;

  assign w_a_neg = i_signed & i_a[WIDTH-1];
  assign w_b_neg = i_signed & i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag_b} : '0);
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_mag_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_mag_b <= '0;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else if (i_load) begin
      r_hi    <= '0;
      r_lo    <= w_a_mag;
      r_mag_b <= w_b_mag;
      r_cnt   <= '0;
      r_div   <= i_div;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_dz    <= i_div & (i_b == '0);
    end else if (i_step) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_div) begin
        if (!w_diff[WIDTH]) begin
          r_hi <= w_diff[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b1};
        end else begin
          r_hi <= w_shift[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        r_hi <= w_sum[WIDTH:1];
        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  assign o_last     = (r_cnt == c_CNT_W'(WIDTH - 1));
  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  // Divide-by-zero keeps an all-ones quotient regardless of sign; the
  // sign-corrected remainder then reproduces the dividend.
  always_comb begin
    o_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    o_lo = w_prod_fix[WIDTH-1:0];
    if (r_div) begin
      o_hi = r_neg_r ? -r_hi : r_hi;
      o_lo = r_dz ? '1 : (r_neg_q ? -r_lo : r_lo);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv_unit.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_muldiv_unit: registered ALU with decode, iterative mul/div   |
// | and HI/LO, start/busy/done handshake.       Rev 1.0             |
// +-----------------------------------------------------------------+
module alu_muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_ctrl;
  logic             r_ill;

  dec_t             w_dec;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_signed;
  logic             w_step;
  logic             w_it_last;
  logic [WIDTH-1:0] w_it_hi;
  logic [WIDTH-1:0] w_it_lo;
  logic [WIDTH-1:0] w_exec;

  assign w_dec    = alu_decode(ALUOp, funct);
  assign alu_ctrl = w_dec.ctrl;

  assign w_accept = start & ~busy;
  assign w_is_mul = (w_dec.ctrl == c_CTRL_MULT) || (w_dec.ctrl == c_CTRL_MULTU);
  assign w_is_div = (w_dec.ctrl == c_CTRL_DIV)  || (w_dec.ctrl == c_CTRL_DIVU);
  assign w_signed = (w_dec.ctrl == c_CTRL_MULT) || (w_dec.ctrl == c_CTRL_DIV);
  assign w_step   = (r_state == S_MUL) || (r_state == S_DIV);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (reset),
    .i_load   (w_accept & (w_is_mul | w_is_div)),
    .i_div    (w_is_div),
    .i_signed (w_signed),
    .i_a      (a),
    .i_b      (b),
    .i_step   (w_step),
    .o_last   (w_it_last),
    .o_hi     (w_it_hi),
    .o_lo     (w_it_lo)
  );

  always_comb begin
    w_exec = r_a & r_b;
    case (r_ctrl)
      c_CTRL_OR:   w_exec = r_a | r_b;
      c_CTRL_ADD:  w_exec = r_a + r_b;
      c_CTRL_XOR:  w_exec = r_a ^ r_b;
      c_CTRL_SUB:  w_exec = r_a - r_b;
      c_CTRL_SLT:  w_exec = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      c_CTRL_SLTU: w_exec = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
      c_CTRL_MFHI: w_exec = hi;
      c_CTRL_MFLO: w_exec = lo;
      c_CTRL_NOR:  w_exec = ~(r_a | r_b);
      default:     w_exec = r_a & r_b;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_ctrl  <= c_CTRL_AND;
      r_ill   <= 1'b0;
      result  <= '0;
      zero    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_EXEC: begin
          result  <= w_exec;
          zero    <= (w_exec == '0);
          illegal <= r_ill;
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        S_MUL, S_DIV: begin
          if (w_it_last) r_state <= S_FIN;
        end
        S_FIN: begin
          result  <= w_it_lo;
          zero    <= (w_it_lo == '0);
          illegal <= 1'b0;
          hi      <= w_it_hi;
          lo      <= w_it_lo;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // busy is low in IDLE and EXEC, so a new op can overlap the done cycle
      if (w_accept) begin
        r_a    <= a;
        r_b    <= b;
        r_ctrl <= w_dec.ctrl;
        r_ill  <= w_dec.illegal;
        busy   <= w_is_mul | w_is_div;
        if (w_is_mul)      r_state <= S_MUL;
        else if (w_is_div) r_state <= S_DIV;
        else               r_state <= S_EXEC;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_unit.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_alu_muldiv_unit: directed vectors with a queue scoreboard.    |
// |                                             Rev 1.0             |
// +-----------------------------------------------------------------+
module tb_alu_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  ALUOp;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [31:0] hi;
  logic [31:0] lo;

  alu_muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ALUOp    (ALUOp),
    .funct    (funct),
    .a        (a),
    .b        (b),
    .alu_ctrl (alu_ctrl),
    .result   (result),
    .zero     (zero),
    .busy     (busy),
    .done     (done),
    .illegal  (illegal),
    .hi       (hi),
    .lo       (lo)
  );

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    logic [31:0] h;
    logic [31:0] l;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no completion", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".result"},  result, e.res);
        chk({e.name, ".zero"},    {31'd0, zero}, {31'd0, e.z});
        chk({e.name, ".illegal"}, {31'd0, illegal}, {31'd0, e.ill});
        chk({e.name, ".hi"},      hi, e.h);
        chk({e.name, ".lo"},      lo, e.l);
        chk({e.name, ".cycle"},   cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; accept edge is the next posedge.
  task automatic send(input logic [1:0] op, input logic [5:0] fn,
                      input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] res, input logic z, input logic ill,
                      input logic [31:0] h, input logic [31:0] l,
                      input int lat, input string nm);
    exp_t e;
    ALUOp = op; funct = fn; a = av; b = bv; start = 1'b1;
    e.res = res; e.z = z; e.ill = ill; e.h = h; e.l = l;
    e.cyc = cyc + 1 + lat; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
  endtask

  task automatic wait_idle(input string nm);
    int i;
    for (i = 0; i < 100; i++) begin
      if (sb.size() == 0 && busy == 1'b0) break;
      @(negedge clk);
    end
    if (i == 100) chk({nm, ".timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_done(input string nm);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done == 1'b1) break;
    end
    if (i == 100) chk({nm, ".timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; ALUOp = 2'b00; funct = 6'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst.result",  result, 32'h0);
    chk("rst.zero",    {31'd0, zero}, 32'd1);
    chk("rst.busy",    {31'd0, busy}, 32'd0);
    chk("rst.done",    {31'd0, done}, 32'd0);
    chk("rst.illegal", {31'd0, illegal}, 32'd0);
    chk("rst.hi",      hi, 32'h0);
    chk("rst.lo",      lo, 32'h0);
    reset = 1'b0;

    ALUOp = 2'b10; funct = 6'b011010; #1;
    chk("ctrl.div", {28'd0, alu_ctrl}, 32'hD);
    ALUOp = 2'b11; #1;
    chk("ctrl.ori", {28'd0, alu_ctrl}, 32'h1);
    ALUOp = 2'b10; funct = 6'b111111; #1;
    chk("ctrl.illegal", {28'd0, alu_ctrl}, 32'h0);
    @(negedge clk);

    // Single-cycle ops, one per cycle
    send(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0, 1, "slt");
    send(2'b10, 6'b101011, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1, "sltu");
    send(2'b00, 6'b000000, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1, "add_wrap");
    send(2'b01, 6'b000000, 32'h5, 32'h7, 32'hFFFFFFFE, 1'b0, 1'b0, 32'h0, 32'h0, 1, "sub");
    send(2'b11, 6'b000000, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 32'h0, 32'h0, 1, "ori");
    send(2'b10, 6'b100100, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0, 32'h0, 32'h0, 1, "and");
    send(2'b10, 6'b100110, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0, 1'b0, 32'h0, 32'h0, 1, "xor");
    send(2'b10, 6'b100111, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 32'h0, 1, "nor");
    send(2'b10, 6'b111111, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b1, 32'h0, 32'h0, 1, "illegal");
    send(2'b10, 6'b100001, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, 1, "addu");
    wait_idle("single");

    send(2'b10, 6'b011000, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, "mult");
    chk("mult.busy", {31'd0, busy}, 32'd1);
    wait_idle("mult");
    send(2'b10, 6'b011001, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 1'b0, 1'b0, 32'h6, 32'hFFFFFFEB, 33, "multu");
    wait_idle("multu");
    send(2'b10, 6'b010000, 32'h0, 32'h0, 32'h6, 1'b0, 1'b0, 32'h6, 32'hFFFFFFEB, 1, "mfhi");
    send(2'b10, 6'b010010, 32'h0, 32'h0, 32'hFFFFFFEB, 1'b0, 1'b0, 32'h6, 32'hFFFFFFEB, 1, "mflo");
    wait_idle("mf");
    send(2'b10, 6'b011000, 32'h80000000, 32'h80000000, 32'h0, 1'b1, 1'b0, 32'h40000000, 32'h0, 33, "mult_minmin");
    wait_idle("mult_minmin");

    // DIV, ignored start while busy, then back-to-back issues in done cycles
    send(2'b10, 6'b011010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, "div");
    repeat (5) @(negedge clk);
    ALUOp = 2'b00; a = 32'h1; b = 32'h2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("div");
    send(2'b10, 6'b011011, 32'd100, 32'd7, 32'hE, 1'b0, 1'b0, 32'h2, 32'hE, 33, "divu_b2b");
    wait_done("divu_b2b");
    send(2'b00, 6'b000000, 32'd3, 32'd4, 32'h7, 1'b0, 1'b0, 32'h2, 32'hE, 1, "add_b2b");
    wait_idle("b2b");

    send(2'b10, 6'b011011, 32'h7, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h7, 32'hFFFFFFFF, 33, "divu_by0");
    wait_idle("divu_by0");
    send(2'b10, 6'b011010, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFF9, 32'hFFFFFFFF, 33, "div_by0");
    wait_idle("div_by0");
    send(2'b10, 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 32'h0, 32'h80000000, 33, "div_ovf");
    wait_idle("div_ovf");
    send(2'b10, 6'b010000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h80000000, 1, "mfhi_ovf");
    wait_idle("mfhi_ovf");

    // Reset in the middle of a MULT
    ALUOp = 2'b10; funct = 6'b011000; a = 32'hFFFFFFFD; b = 32'h7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst.busy_before", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst.result",  result, 32'h0);
    chk("midrst.zero",    {31'd0, zero}, 32'd1);
    chk("midrst.busy",    {31'd0, busy}, 32'd0);
    chk("midrst.done",    {31'd0, done}, 32'd0);
    chk("midrst.illegal", {31'd0, illegal}, 32'd0);
    chk("midrst.hi",      hi, 32'h0);
    chk("midrst.lo",      lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(2'b10, 6'b010010, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1, "mflo_after_rst");
    wait_idle("mflo_after_rst");
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
